// File: rtl/imsic_msi_axi_sender.sv
// MSI transmit side for an IMSIC write port: queues MSI requests and issues each
// one as a single-beat AXI-lite write, reporting the B response as a done/error pulse.
module imsic_msi_axi_sender #(
  parameter int AXI_ID_WIDTH   = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int MST_ID         = 0,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      msi_req_valid,
  output logic                      msi_req_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] msi_req_addr,
  input  logic [31:0]               msi_req_data,
  output logic                      awvalid_m,
  input  logic                      awready_m,
  output logic [AXI_ADDR_WIDTH-1:0] awaddr_m,
  output logic [AXI_ID_WIDTH-1:0]   awid_m,
  output logic                      wvalid_m,
  input  logic                      wready_m,
  output logic [31:0]               wdata_m,
  output logic [3:0]                wstrb_m,
  input  logic                      bvalid_m,
  output logic                      bready_m,
  input  logic [1:0]                bresp_m,
  input  logic [AXI_ID_WIDTH-1:0]   bid_m,
  output logic                      msi_done,
  output logic                      msi_err,
  output logic [1:0]                err_resp,
  output logic                      busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [AXI_ID_WIDTH-1:0] MST_ID_V = AXI_ID_WIDTH'(MST_ID);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, WAIT_B = 2'd2} state_t;

  logic [AXI_ADDR_WIDTH+31:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]           count_r, count_next_s;
  logic                       ready_r, nempty_r;
  state_t                     state_r, state_next_s;
  logic                       aw_done_r, w_done_r, aw_done_next_s, w_done_next_s;
  logic                       awvalid_r, wvalid_r, bready_r, done_r, err_r;
  logic                       awvalid_next_s, wvalid_next_s, bready_next_s, done_next_s, err_next_s;
  logic [AXI_ADDR_WIDTH-1:0]  awaddr_r, awaddr_next_s;
  logic [31:0]                wdata_r, wdata_next_s;
  logic [1:0]                 err_resp_r, err_resp_next_s;
  logic                       push_s, pop_s, aw_fin_s, w_fin_s, b_ok_s;

  assign push_s = msi_req_valid & ready_r;

  // Next-state and next-output logic for the transaction FSM and FIFO count
  always_comb begin
    state_next_s    = state_r;
    pop_s           = 1'b0;
    awvalid_next_s  = awvalid_r;
    wvalid_next_s   = wvalid_r;
    bready_next_s   = bready_r;
    awaddr_next_s   = awaddr_r;
    wdata_next_s    = wdata_r;
    aw_done_next_s  = aw_done_r;
    w_done_next_s   = w_done_r;
    done_next_s     = 1'b0;
    err_next_s      = 1'b0;
    err_resp_next_s = err_resp_r;
    aw_fin_s        = 1'b0;
    w_fin_s         = 1'b0;
    b_ok_s          = 1'b0;
    case (state_r)
      IDLE: begin
        // nempty_r lags the count by one cycle, giving the two-edge issue latency
        if (nempty_r && (count_r != CNT_ZERO)) begin
          pop_s          = 1'b1;
          {awaddr_next_s, wdata_next_s} = mem_r[rd_ptr_r];
          awvalid_next_s = 1'b1;
          wvalid_next_s  = 1'b1;
          aw_done_next_s = 1'b0;
          w_done_next_s  = 1'b0;
          state_next_s   = SEND;
        end else begin
          state_next_s = IDLE;
        end
      end
      SEND: begin
        aw_fin_s       = aw_done_r | (awvalid_r & awready_m);
        w_fin_s        = w_done_r | (wvalid_r & wready_m);
        awvalid_next_s = awvalid_r & ~awready_m;
        wvalid_next_s  = wvalid_r & ~wready_m;
        aw_done_next_s = aw_fin_s;
        w_done_next_s  = w_fin_s;
        if (aw_fin_s && w_fin_s) begin
          bready_next_s = 1'b1;
          state_next_s  = WAIT_B;
        end else begin
          state_next_s = SEND;
        end
      end
      WAIT_B: begin
        b_ok_s = (bresp_m == 2'b00) && (bid_m == MST_ID_V);
        if (bvalid_m && bready_r) begin
          bready_next_s = 1'b0;
          state_next_s  = IDLE;
          if (b_ok_s) begin
            done_next_s = 1'b1;
          end else begin
            err_next_s      = 1'b1;
            err_resp_next_s = bresp_m;
          end
        end else begin
          state_next_s = WAIT_B;
        end
      end
      default: begin
        state_next_s   = IDLE;
        awvalid_next_s = 1'b0;
        wvalid_next_s  = 1'b0;
        bready_next_s  = 1'b0;
      end
    endcase

    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // State, FIFO bookkeeping and registered AXI/status outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r    <= IDLE;
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= CNT_ZERO;
      ready_r    <= 1'b1;
      nempty_r   <= 1'b0;
      aw_done_r  <= 1'b0;
      w_done_r   <= 1'b0;
      awvalid_r  <= 1'b0;
      wvalid_r   <= 1'b0;
      bready_r   <= 1'b0;
      awaddr_r   <= {AXI_ADDR_WIDTH{1'b0}};
      wdata_r    <= 32'h0000_0000;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      err_resp_r <= 2'b00;
    end else begin
      state_r    <= state_next_s;
      wr_ptr_r   <= push_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
      rd_ptr_r   <= pop_s ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
      count_r    <= count_next_s;
      ready_r    <= (count_next_s != CNT_FULL);
      nempty_r   <= (count_r != CNT_ZERO);
      aw_done_r  <= aw_done_next_s;
      w_done_r   <= w_done_next_s;
      awvalid_r  <= awvalid_next_s;
      wvalid_r   <= wvalid_next_s;
      bready_r   <= bready_next_s;
      awaddr_r   <= awaddr_next_s;
      wdata_r    <= wdata_next_s;
      done_r     <= done_next_s;
      err_r      <= err_next_s;
      err_resp_r <= err_resp_next_s;
    end
  end

  // Request storage; contents need no reset since the pointers gate all reads
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {msi_req_addr, msi_req_data};
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  assign msi_req_ready = ready_r;
  assign awvalid_m     = awvalid_r;
  assign awaddr_m      = awaddr_r;
  assign awid_m        = MST_ID_V;
  assign wvalid_m      = wvalid_r;
  assign wdata_m       = wdata_r;
  assign wstrb_m       = 4'hF;
  assign bready_m      = bready_r;
  assign msi_done      = done_r;
  assign msi_err       = err_r;
  assign err_resp      = err_resp_r;
  assign busy          = (count_r != CNT_ZERO) || (state_r != IDLE);

endmodule

// File: tb/tb_imsic_msi_axi_sender.sv
// Directed self-checking bench for imsic_msi_axi_sender acting as a simple AXI-lite slave.
module tb_imsic_msi_axi_sender;

  logic        clk = 1'b0;
  logic        rstn;
  logic        msi_req_valid, msi_req_ready;
  logic [31:0] msi_req_addr, msi_req_data;
  logic        awvalid_m, awready_m;
  logic [31:0] awaddr_m, awid_m;
  logic        wvalid_m, wready_m;
  logic [31:0] wdata_m;
  logic [3:0]  wstrb_m;
  logic        bvalid_m, bready_m;
  logic [1:0]  bresp_m;
  logic [31:0] bid_m;
  logic        msi_done, msi_err;
  logic [1:0]  err_resp;
  logic        busy;

  int total = 0;
  int bad   = 0;

  imsic_msi_axi_sender #(
    .AXI_ID_WIDTH(32), .AXI_ADDR_WIDTH(32), .MST_ID(0), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rstn(rstn),
    .msi_req_valid(msi_req_valid), .msi_req_ready(msi_req_ready),
    .msi_req_addr(msi_req_addr), .msi_req_data(msi_req_data),
    .awvalid_m(awvalid_m), .awready_m(awready_m), .awaddr_m(awaddr_m), .awid_m(awid_m),
    .wvalid_m(wvalid_m), .wready_m(wready_m), .wdata_m(wdata_m), .wstrb_m(wstrb_m),
    .bvalid_m(bvalid_m), .bready_m(bready_m), .bresp_m(bresp_m), .bid_m(bid_m),
    .msi_done(msi_done), .msi_err(msi_err), .err_resp(err_resp), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    logic acc;
    acc = 1'b0;
    msi_req_valid = 1'b1;
    msi_req_addr  = a;
    msi_req_data  = d;
    for (int n = 0; n < 20 && !acc; n++) begin
      acc = msi_req_ready;
      tick();
    end
    msi_req_valid = 1'b0;
    check("push_accept", 64'(acc), 64'(1));
  endtask

  // Play the slave for one write: AW/W ready after given delays, then one B beat
  task automatic serve(input int aw_lat, input int w_lat, input logic [1:0] resp,
                       input logic [31:0] id, input logic [31:0] ea, input logic [31:0] ed);
    int   n;
    logic aw_ok, w_ok, exp_ok;
    n = 0;
    while (awvalid_m !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("aw_wait", 64'(awvalid_m), 64'(1));
    check("awaddr", 64'(awaddr_m), 64'(ea));
    check("wdata", 64'(wdata_m), 64'(ed));
    check("wvalid", 64'(wvalid_m), 64'(1));
    check("wstrb", 64'(wstrb_m), 64'(4'hF));
    check("awid", 64'(awid_m), 64'(0));
    aw_ok = 1'b0;
    w_ok  = 1'b0;
    for (int c = 0; c < 20 && !(aw_ok && w_ok); c++) begin
      check("bready_early", 64'(bready_m), 64'(0));
      awready_m = !aw_ok && (c >= aw_lat);
      wready_m  = !w_ok && (c >= w_lat);
      tick();
      if (awready_m) aw_ok = 1'b1;
      if (wready_m) w_ok = 1'b1;
      awready_m = 1'b0;
      wready_m  = 1'b0;
      check("awvalid_hold", 64'(awvalid_m), 64'(!aw_ok));
      check("wvalid_hold", 64'(wvalid_m), 64'(!w_ok));
      if (!aw_ok) check("awaddr_stable", 64'(awaddr_m), 64'(ea));
      check("bready", 64'(bready_m), 64'(aw_ok && w_ok));
    end
    bvalid_m = 1'b1;
    bresp_m  = resp;
    bid_m    = id;
    tick();
    bvalid_m = 1'b0;
    bresp_m  = 2'b00;
    bid_m    = 32'd0;
    exp_ok = (resp == 2'b00) && (id == 32'd0);
    check("msi_done", 64'(msi_done), 64'(exp_ok));
    check("msi_err", 64'(msi_err), 64'(!exp_ok));
    check("bready_clr", 64'(bready_m), 64'(0));
    if (!exp_ok) check("err_resp", 64'(err_resp), 64'(resp));
    tick();
    check("done_pulse", 64'(msi_done), 64'(0));
    check("err_pulse", 64'(msi_err), 64'(0));
  endtask

  initial begin
    logic seen;
    rstn = 1'b0;
    msi_req_valid = 1'b0; msi_req_addr = 32'd0; msi_req_data = 32'd0;
    awready_m = 1'b0; wready_m = 1'b0;
    bvalid_m = 1'b0; bresp_m = 2'b00; bid_m = 32'd0;
    tick();
    tick();
    check("rst_awvalid", 64'(awvalid_m), 64'(0));
    check("rst_wvalid", 64'(wvalid_m), 64'(0));
    check("rst_bready", 64'(bready_m), 64'(0));
    check("rst_done", 64'(msi_done), 64'(0));
    check("rst_err", 64'(msi_err), 64'(0));
    check("rst_err_resp", 64'(err_resp), 64'(0));
    check("rst_awaddr", 64'(awaddr_m), 64'(0));
    check("rst_wdata", 64'(wdata_m), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ready", 64'(msi_req_ready), 64'(1));
    rstn = 1'b1;
    tick();

    // Single request: two-edge issue latency, OKAY completion
    push(32'h1000_0000, 32'd5);
    check("lat_e0", 64'(awvalid_m), 64'(0));
    check("busy_queued", 64'(busy), 64'(1));
    tick();
    check("lat_e1", 64'(awvalid_m), 64'(0));
    tick();
    check("lat_e2", 64'(awvalid_m), 64'(1));
    serve(0, 0, 2'b00, 32'd0, 32'h1000_0000, 32'd5);
    check("busy_idle", 64'(busy), 64'(0));

    // Five back-to-back pushes while AW is stalled: FIFO fills, order preserved
    for (int i = 1; i <= 5; i++) push(32'h2000_0000 + 32'(i * 4), 32'(i));
    check("full_ready", 64'(msi_req_ready), 64'(0));
    for (int i = 1; i <= 5; i++) serve(0, 0, 2'b00, 32'd0, 32'h2000_0000 + 32'(i * 4), 32'(i));
    check("drain_ready", 64'(msi_req_ready), 64'(1));

    // Independent AW/W handshakes in both orders
    push(32'h3000_0000, 32'hA);
    serve(3, 0, 2'b00, 32'd0, 32'h3000_0000, 32'hA);
    push(32'h3000_0004, 32'hB);
    serve(0, 3, 2'b00, 32'd0, 32'h3000_0004, 32'hB);

    // DECERR reported, queued follower still issues, err_resp holds
    push(32'h4000_0000, 32'd7);
    push(32'h4000_0004, 32'd8);
    serve(0, 0, 2'b11, 32'd0, 32'h4000_0000, 32'd7);
    serve(1, 1, 2'b00, 32'd0, 32'h4000_0004, 32'd8);
    check("err_resp_hold", 64'(err_resp), 64'(2'b11));

    // OKAY with a foreign ID is an error reported as err_resp=00
    push(32'h5000_0000, 32'd9);
    serve(0, 0, 2'b00, 32'd5, 32'h5000_0000, 32'd9);

    // Reset in SEND with two entries queued discards everything
    push(32'h6000_0000, 32'd1);
    push(32'h6000_0004, 32'd2);
    push(32'h6000_0008, 32'd3);
    check("send_before_rst", 64'(awvalid_m), 64'(1));
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("mrst_awvalid", 64'(awvalid_m), 64'(0));
    check("mrst_wvalid", 64'(wvalid_m), 64'(0));
    check("mrst_bready", 64'(bready_m), 64'(0));
    check("mrst_busy", 64'(busy), 64'(0));
    check("mrst_ready", 64'(msi_req_ready), 64'(1));
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (awvalid_m !== 1'b0) seen = 1'b1;
    end
    check("no_aw_after_rst", 64'(seen), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
